// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the program-counter stage.
package pc_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;

  // Encoding 2'd3 is unused; the FSM treats it like BOOT.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Instruction-fetch request channel: valid/ready handshake plus wrong-path kill.
interface pc_unit_if;
  import pc_unit_pkg::*;

  logic            fetch_valid;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ready;
  logic            fetch_kill;

  modport master (
    output fetch_valid,
    output fetch_addr,
    output fetch_kill,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    input  fetch_kill,
    output fetch_ready
  );

endinterface

// File: rtl/pc_unit_reg32.sv
// 32-bit register with synchronous load enable and a parameterised reset value.
module pc_unit_reg32
  import pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] val_q;
  logic [XLEN-1:0] val_d;

  always_comb begin
    val_d = en ? d : val_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds the PC, issues fetches over valid/ready and
// defers redirects that arrive while a request is blocked.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  input  logic            redirect,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  pc_unit_if.master       fetch
);

  state_e          state_q, state_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            fetch_kill_q, fetch_kill_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pc_load, pend_load;
  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q;
  logic            transfer;

  pc_unit_reg32 #(.RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_load),
    .d   (pc_d),
    .q   (pc_q)
  );

  pc_unit_reg32 #(.RESET_VAL('0)) u_pend_reg (
    .clk (clk),
    .rst (rst),
    .en  (pend_load),
    .d   (next_pc),
    .q   (pend_pc_q)
  );

  assign pc_plus4 = pc_q + PC_STEP;
  assign transfer = fetch_valid_q & fetch.fetch_ready;

  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b0;
    pc_d         = next_pc;
    pend_valid_d = pend_valid_q;
    pend_load    = 1'b0;
    fetch_kill_d = 1'b0;
    case (state_q)
      REQ: begin
        if (transfer) begin
          pc_load      = 1'b1;
          pc_d         = redirect ? next_pc : (pend_valid_q ? pend_pc_q : pc_plus4);
          pend_valid_d = 1'b0;
          fetch_kill_d = redirect | pend_valid_q;
          state_d      = stall ? STALL : REQ;
        end else if (redirect) begin
          // Request must stay stable; remember only the most recent target.
          pend_valid_d = 1'b1;
          pend_load    = 1'b1;
        end
      end
      STALL: begin
        pc_load      = redirect | pend_valid_q;
        pc_d         = redirect ? next_pc : pend_pc_q;
        pend_valid_d = 1'b0;
        if (!stall) begin
          state_d = REQ;
        end
      end
      default: begin
        pc_load = redirect;
        state_d = stall ? STALL : REQ;
      end
    endcase
    fetch_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      fetch_valid_q <= 1'b0;
      fetch_kill_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_kill_q  <= fetch_kill_d;
      pend_valid_q  <= pend_valid_d;
    end
  end

  assign pc               = pc_q;
  assign fetch.fetch_valid = fetch_valid_q;
  assign fetch.fetch_addr  = pc_q;
  assign fetch.fetch_kill  = fetch_kill_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural fetch-stream model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  pc_unit_if fif ();

  pc_unit dut (
    .clk      (clk),
    .rst      (rst),
    .next_pc  (next_pc),
    .redirect (redirect),
    .stall    (stall),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .fetch    (fif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: what the fetch stream must look like, in terms of "a request is
  // being offered", "we are just out of reset", and a list of deferred targets.
  logic [31:0] m_pc;
  logic        m_offering;
  logic        m_fresh;
  logic        m_kill;
  logic        m_init = 1'b0;
  logic [31:0] deferred[$];

  always @(posedge clk) begin
    if (rst) begin
      m_pc       = 32'h0;
      m_offering = 1'b0;
      m_fresh    = 1'b1;
      m_kill     = 1'b0;
      deferred.delete();
      m_init     = 1'b1;
    end else if (m_init) begin
      logic accepted;
      logic [31:0] target;
      accepted = m_offering && fif.fetch_ready;
      m_kill   = 1'b0;
      if (m_fresh) begin
        if (redirect) m_pc = next_pc;
        m_fresh    = 1'b0;
        m_offering = !stall;
      end else if (m_offering && !accepted) begin
        if (redirect) deferred = '{next_pc};
      end else begin
        // Either a fetch was just accepted, or we are waiting out a stall.
        if (redirect) target = next_pc;
        else if (deferred.size() > 0) target = deferred[0];
        else if (accepted) target = m_pc + 32'd4;
        else target = m_pc;
        if (accepted) begin
          m_kill     = redirect || (deferred.size() > 0);
          m_offering = !stall;
        end else begin
          m_offering = !stall;
        end
        m_pc = target;
        deferred.delete();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init && !rst) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("fetch_addr", fif.fetch_addr, m_pc);
      check("fetch_valid", {31'b0, fif.fetch_valid}, {31'b0, m_offering});
      check("fetch_kill", {31'b0, fif.fetch_kill}, {31'b0, m_kill});
    end
  end

  task automatic set_in(input logic r, input logic rd, input logic [31:0] np,
                        input logic st, input logic rdy);
    rst             = r;
    redirect        = rd;
    next_pc         = np;
    stall           = st;
    fif.fetch_ready = rdy;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Literal expectations checked against both the DUT and the model.
  task automatic pin(input string name, input logic [31:0] addr, input logic v, input logic k);
    check({name, ".addr"}, fif.fetch_addr, addr);
    check({name, ".valid"}, {31'b0, fif.fetch_valid}, {31'b0, v});
    check({name, ".kill"}, {31'b0, fif.fetch_kill}, {31'b0, k});
    check({name, ".model_addr"}, m_pc, addr);
    check({name, ".model_valid"}, {31'b0, m_offering}, {31'b0, v});
  endtask

  initial begin
    set_in(1, 0, 32'h0, 0, 1);
    tick(); tick();
    pin("reset", 32'h0, 0, 0);

    // Free run from BOOT.
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("seq0", 32'h0, 1, 0);
    tick(); pin("seq1", 32'h4, 1, 0);
    tick(); pin("seq2", 32'h8, 1, 0);
    tick(); pin("seq3", 32'hC, 1, 0);
    tick(); pin("seq4", 32'h10, 1, 0);

    // Backpressure at 0x10 with stall toggling.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 32'h0, i[0], 0);
      tick(); pin("bp_hold", 32'h10, 1, 0);
    end
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("bp_next", 32'h14, 1, 0);

    // Redirect twice while blocked at 0x20.
    set_in(0, 1, 32'h20, 0, 1);
    tick(); pin("to20", 32'h20, 1, 1);
    set_in(0, 1, 32'h100, 0, 0);
    tick(); pin("blk1", 32'h20, 1, 0);
    set_in(0, 1, 32'h200, 0, 0);
    tick(); pin("blk2", 32'h20, 1, 0);
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("pend_tgt", 32'h200, 1, 1);

    // Redirect coincident with transfer at 0x40.
    set_in(0, 1, 32'h3C, 0, 1);
    tick(); pin("to3c", 32'h3C, 1, 1);
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("at40", 32'h40, 1, 0);
    set_in(0, 1, 32'h80, 0, 1);
    tick(); pin("co_tgt", 32'h80, 1, 1);
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("co_after", 32'h84, 1, 0);

    // Wrap into a stall, redirect while stalled.
    set_in(0, 1, 32'hFFFF_FFF8, 0, 1);
    tick(); pin("to_fff8", 32'hFFFF_FFF8, 1, 1);
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("at_fffc", 32'hFFFF_FFFC, 1, 0);
    set_in(0, 0, 32'h0, 1, 1);
    tick(); pin("wrap", 32'h0, 0, 0);
    set_in(0, 1, 32'h300, 1, 1);
    tick(); pin("stall_rd", 32'h300, 0, 0);
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("stall_out", 32'h300, 1, 0);

    // Reset in the middle of a blocked request with a deferred redirect.
    set_in(0, 1, 32'h50, 0, 1);
    tick(); pin("to50", 32'h50, 1, 1);
    set_in(0, 1, 32'h999, 0, 0);
    tick(); pin("blk50", 32'h50, 1, 0);
    set_in(1, 0, 32'h0, 0, 0);
    tick(); pin("mid_rst", 32'h0, 0, 0);
    set_in(0, 0, 32'h0, 0, 1);
    tick(); pin("post_rst0", 32'h0, 1, 0);
    tick(); pin("post_rst1", 32'h4, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] np;
      np = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_FFFC);
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, np,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the 32-bit 2:1 next-PC mux.
- The mux's `a` input is `pc_plus4` from this block, its `b` input is the branch/jump target, and its select is `redirect`. Its output `f` drives `next_pc` here.
- Holds the architectural PC, issues instruction-fetch requests over a valid/ready handshake, and defers redirects that arrive while a fetch is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment added to form pc_plus4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- next_pc  input  32  next-PC mux output; consumed only when redirect=1.
- redirect  input  1  1 = load next_pc (taken branch/jump); also drives the mux select.
- stall  input  1  downstream hazard stall; suppresses new fetch issue.
- pc  output  32  current PC register value.
- pc_plus4  output  32  pc + PC_STEP, combinational, mod 2^32; feeds mux input `a`.
- fetch_valid  output  1  fetch request valid.
- fetch_addr  output  32  fetch address, always equal to pc.
- fetch_ready  input  1  instruction memory accepts request.
- fetch_kill  output  1  registered one-cycle pulse: the fetch accepted on the previous edge is wrong-path.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=BOOT, pend_valid=0, pend_pc=0, fetch_kill=0.
  - fetch_valid=0 while in BOOT.
  - rst overrides every other input; any in-flight request is abandoned.
- Handshake:
  - Transfer occurs on a cycle with fetch_valid=1 && fetch_ready=1.
  - Once fetch_valid=1, it and fetch_addr stay stable until the transfer. Neither stall nor redirect may drop or change them mid-request.
- Arithmetic: pc_plus4 wraps, so 32'hFFFF_FFFC -> 32'h0000_0000. No alignment checks; pc low bits are passed through as loaded.
- States (2-bit, fetch_valid=1 only in REQ):
  - BOOT: next state is STALL if stall else REQ. pc unchanged unless redirect=1, which loads pc<=next_pc.
  - REQ, transfer cycle:
    - pc <= next_pc if redirect; else pend_pc if pend_valid; else pc_plus4.
    - pend_valid<=0.
    - fetch_kill<=redirect|pend_valid.
    - next state STALL if stall else REQ.
  - REQ, no transfer:
    - pc held.
    - If redirect: pend_valid<=1, pend_pc<=next_pc; a later redirect overwrites the earlier one.
    - Stay in REQ regardless of stall.
    - fetch_kill<=0.
  - STALL:
    - pc <= next_pc if redirect; else pend_pc if pend_valid; else held.
    - pend_valid<=0.
    - next state REQ when stall=0.
    - fetch_kill<=0.
- Latency:
  - Redirect when no request is pending: fetch_addr shows the target on the next cycle.
  - Sequential issue with fetch_ready tied 1 and stall=0: one fetch per cycle, addresses increment by 4.
- Simultaneous redirect + transfer: the transferred address is the old pc, so fetch_kill pulses next cycle, and the target is the next issued address.
- fetch_kill is asserted only for one cycle following a transfer.

Decomposition:
- Shared package holds:
  - state typedef/encoding: BOOT=2'd0, REQ=2'd1, STALL=2'd2; 2'd3 is illegal and decodes to BOOT.
  - PC_STEP and RESET_PC defaults.
  - XLEN=32.
- One natural sub-module: _reg32, a 32-bit register with synchronous load enable and reset value, modelled on an octal D-flop part. Instantiate it for pc and for pend_pc.
- The adder and next-value selection stay in pc_unit.

Test Plan:
- Reset then free-run, fetch_ready=1, stall=0: BOOT one cycle, then fetch_addr 0x0, 0x4, 0x8, 0xC on consecutive cycles; fetch_kill=0 throughout.
- Backpressure: fetch_ready=0 for 3 cycles at pc=0x10 with stall toggling: fetch_valid=1 and fetch_addr=0x10 held stable; after ready=1, next address 0x14.
- Redirect while blocked: pc=0x20, ready=0, redirect with next_pc=0x100, then redirect with 0x200, then ready=1. Required: transfer at 0x20, fetch_kill=1 next cycle, next fetch_addr=0x200.
- Redirect coincident with transfer at 0x40, next_pc=0x80: next fetch_addr=0x80, fetch_kill pulses exactly one cycle.
- Wrap and stall: pc=0xFFFF_FFFC, transfer with stall=1. Required: pc=0x0, fetch_valid=0 while stalled, redirect in STALL to 0x300 gives fetch_addr=0x300 once stall drops.
- Mid-request reset: rst=1 while fetch_valid=1 at 0x50. Required: next cycle pc=RESET_PC, fetch_valid=0, pend_valid=0, fetch_kill=0.
